lockstep_fifo_array: RTL and testbench

Redundant FIFO holding NUM_CH replicas of every word, written and popped in lockstep from one shared write/read interface. Each popped word is compared across channels, optionally majority-voted, and flagged on disagreement. Per-channel fault injection lets benches and formal checks exercise the compare and vote logic. It is the parametrised successor to the two-FIFO lockstep arrangement, generalised to N channels and fitted for SEU-tolerant buffering in the datapath.

---
 rtl/lockstep_fifo_array.sv | 97 +++++++++
 tb/tb_lockstep_fifo_array.sv | 135 +++++++++++++
 2 files changed

// File: rtl/lockstep_fifo_array.sv
// lockstep_fifo_array: NUM_CH-way replicated FIFO with shared pointers, per-pop
// cross-channel compare, optional bitwise majority vote and fault injection.
module lockstep_fifo_array #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 8,
  parameter int NUM_CH     = 3,
  parameter int VOTE       = 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       wr_en,
  input  logic [DATA_WIDTH-1:0]      wr_data,
  output logic                       wr_ready,
  input  logic                       rd_en,
  output logic [DATA_WIDTH-1:0]      rd_data,
  output logic                       rd_valid,
  output logic [$clog2(DEPTH):0]     count,
  input  logic [NUM_CH-1:0]          inj_sel,
  input  logic [DATA_WIDTH-1:0]      inj_mask,
  input  logic                       err_clr,
  output logic                       mismatch,
  output logic [NUM_CH-1:0]          mismatch_ch,
  output logic                       err_sticky
);
  localparam int AW = $clog2(DEPTH);
  logic [DATA_WIDTH-1:0] mem_q [NUM_CH][DEPTH];
  logic [DATA_WIDTH-1:0] head [NUM_CH];
  logic [DATA_WIDTH-1:0] vote;
  logic [3:0]            ones;
  logic [AW-1:0]         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]           count_q, count_d;
  logic                  mismatch_q, mismatch_d, err_q, err_d;
  logic [NUM_CH-1:0]     mismatch_ch_q, mismatch_ch_d;
  logic                  wr_acc, rd_acc;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_head
    assign head[i] = mem_q[i][rd_ptr_q];
  end

  assign wr_ready    = count_q != (AW+1)'(DEPTH);
  assign rd_valid    = count_q != '0;
  assign wr_acc      = wr_en && wr_ready;
  assign rd_acc      = rd_en && rd_valid;
  assign rd_data     = rd_valid ? vote : '0;
  assign count       = count_q;
  assign mismatch    = mismatch_q;
  assign mismatch_ch = mismatch_ch_q;
  assign err_sticky  = err_q;

  // Exact ties (even NUM_CH) defer to channel 0.
  always_comb begin
    vote = head[0];
    ones = '0;
    for (int b = 0; b < DATA_WIDTH; b++) begin
      ones = '0;
      for (int i = 0; i < NUM_CH; i++) ones = ones + 4'(head[i][b]);
      if (VOTE != 0 && NUM_CH >= 3)
        vote[b] = ({ones, 1'b0} > 5'(NUM_CH)) ? 1'b1 :
                  ({ones, 1'b0} == 5'(NUM_CH)) ? head[0][b] : 1'b0;
    end
  end

  always_comb begin
    wr_ptr_d      = wr_acc ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d      = rd_acc ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d       = count_q + (AW+1)'(wr_acc) - (AW+1)'(rd_acc);
    mismatch_ch_d = mismatch_ch_q;
    for (int i = 0; i < NUM_CH; i++)
      mismatch_ch_d[i] = rd_acc ? (head[i] != rd_data) : mismatch_ch_q[i];
    mismatch_d    = rd_acc && (mismatch_ch_d != '0);
    err_d         = mismatch_d || (err_q && !err_clr);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      mismatch_q    <= 1'b0;
      mismatch_ch_q <= '0;
      err_q         <= 1'b0;
    end else begin
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      mismatch_q    <= mismatch_d;
      mismatch_ch_q <= mismatch_ch_d;
      err_q         <= err_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_acc)
      for (int i = 0; i < NUM_CH; i++)
        mem_q[i][wr_ptr_q] <= wr_data ^ (inj_sel[i] ? inj_mask : '0);
  end
endmodule

// File: tb/tb_lockstep_fifo_array.sv
// tb_lockstep_fifo_array: table-driven directed checks of the lockstep FIFO,
// with a VOTE=0 twin sharing the stimulus for the channel-0 output path.
module tb_lockstep_fifo_array;
  logic       clk = 1'b0, rst_n = 1'b0;
  logic       wr_en = 1'b0, rd_en = 1'b0, err_clr = 1'b0;
  logic [7:0] wr_data = '0, inj_mask = '0;
  logic [2:0] inj_sel = '0;
  logic       wr_ready, rd_valid, mismatch, wr_ready0, rd_valid0, mismatch0;
  logic [7:0] rd_data, rd_data0;
  logic [2:0] count, count0, mismatch_ch, mismatch_ch0;
  logic       err_sticky, err_sticky0;
  int passed = 0, total = 0;

  typedef struct {
    logic w; logic [7:0] wd; logic r; logic [2:0] sel; logic [7:0] mask; logic clr;
    logic v; logic [7:0] rd; logic [2:0] cnt; logic rdy; logic mm; logic [2:0] ch; logic e;
  } vec_t;
  vec_t vecs[$];

  always #5 clk = ~clk;

  lockstep_fifo_array #(.DATA_WIDTH(8), .DEPTH(4), .NUM_CH(3), .VOTE(1)) dut (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_data(wr_data), .wr_ready(wr_ready),
    .rd_en(rd_en), .rd_data(rd_data), .rd_valid(rd_valid), .count(count),
    .inj_sel(inj_sel), .inj_mask(inj_mask), .err_clr(err_clr), .mismatch(mismatch),
    .mismatch_ch(mismatch_ch), .err_sticky(err_sticky));

  lockstep_fifo_array #(.DATA_WIDTH(8), .DEPTH(4), .NUM_CH(3), .VOTE(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_data(wr_data), .wr_ready(wr_ready0),
    .rd_en(rd_en), .rd_data(rd_data0), .rd_valid(rd_valid0), .count(count0),
    .inj_sel(inj_sel), .inj_mask(inj_mask), .err_clr(err_clr), .mismatch(mismatch0),
    .mismatch_ch(mismatch_ch0), .err_sticky(err_sticky0));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic add(input logic w, input logic [7:0] wd, input logic r, input logic [2:0] sel,
                     input logic [7:0] mask, input logic clr, input logic v, input logic [7:0] rd,
                     input logic [2:0] cnt, input logic rdy, input logic mm, input logic [2:0] ch,
                     input logic e);
    vec_t t;
    t.w = w; t.wd = wd; t.r = r; t.sel = sel; t.mask = mask; t.clr = clr;
    t.v = v; t.rd = rd; t.cnt = cnt; t.rdy = rdy; t.mm = mm; t.ch = ch; t.e = e;
    vecs.push_back(t);
  endtask

  task automatic check_all(input string tag, input logic v, input logic [7:0] rd,
                           input logic [2:0] cnt, input logic rdy, input logic mm,
                           input logic [2:0] ch, input logic e);
    chk({tag, ".rd_valid"}, 32'(rd_valid), 32'(v));
    chk({tag, ".rd_data"}, 32'(rd_data), 32'(rd));
    chk({tag, ".count"}, 32'(count), 32'(cnt));
    chk({tag, ".wr_ready"}, 32'(wr_ready), 32'(rdy));
    chk({tag, ".mismatch"}, 32'(mismatch), 32'(mm));
    chk({tag, ".mismatch_ch"}, 32'(mismatch_ch), 32'(ch));
    chk({tag, ".err_sticky"}, 32'(err_sticky), 32'(e));
  endtask

  task automatic drive(input logic w, input logic [7:0] wd, input logic r,
                       input logic [2:0] sel, input logic [7:0] mask, input logic clr);
    wr_en = w; wr_data = wd; rd_en = r; inj_sel = sel; inj_mask = mask; err_clr = clr;
  endtask

  initial begin
    //   w     wd     r     sel     mask   clr | v     rd     cnt   rdy   mm    ch      e
    add(1'b1, 8'hA5, 1'b0, 3'b000, 8'h00, 1'b0, 1'b1, 8'hA5, 3'd1, 1'b1, 1'b0, 3'b000, 1'b0);
    add(1'b1, 8'h3C, 1'b0, 3'b000, 8'h00, 1'b0, 1'b1, 8'hA5, 3'd2, 1'b1, 1'b0, 3'b000, 1'b0);
    add(1'b0, 8'h00, 1'b1, 3'b000, 8'h00, 1'b0, 1'b1, 8'h3C, 3'd1, 1'b1, 1'b0, 3'b000, 1'b0);
    add(1'b0, 8'h00, 1'b1, 3'b000, 8'h00, 1'b0, 1'b0, 8'h00, 3'd0, 1'b1, 1'b0, 3'b000, 1'b0);
    add(1'b0, 8'h00, 1'b1, 3'b000, 8'h00, 1'b0, 1'b0, 8'h00, 3'd0, 1'b1, 1'b0, 3'b000, 1'b0);
    add(1'b1, 8'h01, 1'b0, 3'b000, 8'h00, 1'b0, 1'b1, 8'h01, 3'd1, 1'b1, 1'b0, 3'b000, 1'b0);
    add(1'b1, 8'h02, 1'b0, 3'b000, 8'h00, 1'b0, 1'b1, 8'h01, 3'd2, 1'b1, 1'b0, 3'b000, 1'b0);
    add(1'b1, 8'h03, 1'b0, 3'b000, 8'h00, 1'b0, 1'b1, 8'h01, 3'd3, 1'b1, 1'b0, 3'b000, 1'b0);
    add(1'b1, 8'h04, 1'b0, 3'b000, 8'h00, 1'b0, 1'b1, 8'h01, 3'd4, 1'b0, 1'b0, 3'b000, 1'b0);
    add(1'b1, 8'hFF, 1'b0, 3'b000, 8'h00, 1'b0, 1'b1, 8'h01, 3'd4, 1'b0, 1'b0, 3'b000, 1'b0);
    add(1'b1, 8'hFF, 1'b1, 3'b000, 8'h00, 1'b0, 1'b1, 8'h02, 3'd3, 1'b1, 1'b0, 3'b000, 1'b0);
    add(1'b0, 8'h00, 1'b1, 3'b000, 8'h00, 1'b0, 1'b1, 8'h03, 3'd2, 1'b1, 1'b0, 3'b000, 1'b0);
    add(1'b0, 8'h00, 1'b1, 3'b000, 8'h00, 1'b0, 1'b1, 8'h04, 3'd1, 1'b1, 1'b0, 3'b000, 1'b0);
    add(1'b0, 8'h00, 1'b1, 3'b000, 8'h00, 1'b0, 1'b0, 8'h00, 3'd0, 1'b1, 1'b0, 3'b000, 1'b0);
    add(1'b1, 8'h05, 1'b0, 3'b000, 8'h00, 1'b0, 1'b1, 8'h05, 3'd1, 1'b1, 1'b0, 3'b000, 1'b0);
    add(1'b1, 8'h06, 1'b0, 3'b000, 8'h00, 1'b0, 1'b1, 8'h05, 3'd2, 1'b1, 1'b0, 3'b000, 1'b0);
    add(1'b1, 8'h07, 1'b1, 3'b000, 8'h00, 1'b0, 1'b1, 8'h06, 3'd2, 1'b1, 1'b0, 3'b000, 1'b0);
    add(1'b0, 8'h00, 1'b1, 3'b000, 8'h00, 1'b0, 1'b1, 8'h07, 3'd1, 1'b1, 1'b0, 3'b000, 1'b0);
    add(1'b0, 8'h00, 1'b1, 3'b000, 8'h00, 1'b0, 1'b0, 8'h00, 3'd0, 1'b1, 1'b0, 3'b000, 1'b0);
    add(1'b1, 8'h10, 1'b0, 3'b010, 8'h01, 1'b0, 1'b1, 8'h10, 3'd1, 1'b1, 1'b0, 3'b000, 1'b0);
    add(1'b0, 8'h00, 1'b1, 3'b000, 8'h00, 1'b0, 1'b0, 8'h00, 3'd0, 1'b1, 1'b1, 3'b010, 1'b1);
    add(1'b0, 8'h00, 1'b0, 3'b000, 8'h00, 1'b0, 1'b0, 8'h00, 3'd0, 1'b1, 1'b0, 3'b010, 1'b1);
    add(1'b1, 8'h00, 1'b0, 3'b011, 8'h0F, 1'b0, 1'b1, 8'h0F, 3'd1, 1'b1, 1'b0, 3'b010, 1'b1);
    add(1'b0, 8'h00, 1'b1, 3'b000, 8'h00, 1'b0, 1'b0, 8'h00, 3'd0, 1'b1, 1'b1, 3'b100, 1'b1);
    add(1'b0, 8'h00, 1'b0, 3'b000, 8'h00, 1'b1, 1'b0, 8'h00, 3'd0, 1'b1, 1'b0, 3'b100, 1'b0);
    add(1'b1, 8'h20, 1'b0, 3'b100, 8'h80, 1'b0, 1'b1, 8'h20, 3'd1, 1'b1, 1'b0, 3'b100, 1'b0);
    add(1'b0, 8'h00, 1'b1, 3'b000, 8'h00, 1'b1, 1'b0, 8'h00, 3'd0, 1'b1, 1'b1, 3'b100, 1'b1);
    add(1'b0, 8'h00, 1'b0, 3'b000, 8'h00, 1'b0, 1'b0, 8'h00, 3'd0, 1'b1, 1'b0, 3'b100, 1'b1);
    add(1'b1, 8'h11, 1'b0, 3'b000, 8'h00, 1'b0, 1'b1, 8'h11, 3'd1, 1'b1, 1'b0, 3'b100, 1'b1);
    add(1'b1, 8'h22, 1'b0, 3'b000, 8'h00, 1'b0, 1'b1, 8'h11, 3'd2, 1'b1, 1'b0, 3'b100, 1'b1);
    add(1'b1, 8'h33, 1'b0, 3'b000, 8'h00, 1'b0, 1'b1, 8'h11, 3'd3, 1'b1, 1'b0, 3'b100, 1'b1);

    repeat (2) @(posedge clk);
    #1 check_all("reset", 1'b0, 8'h00, 3'd0, 1'b1, 1'b0, 3'b000, 1'b0);
    @(negedge clk) rst_n = 1'b1;

    foreach (vecs[k]) begin
      @(negedge clk);
      drive(vecs[k].w, vecs[k].wd, vecs[k].r, vecs[k].sel, vecs[k].mask, vecs[k].clr);
      @(posedge clk);
      #1 check_all($sformatf("vec%0d", k), vecs[k].v, vecs[k].rd, vecs[k].cnt, vecs[k].rdy,
                   vecs[k].mm, vecs[k].ch, vecs[k].e);
    end

    // Asynchronous reset asserted between edges with three words queued.
    #2 rst_n = 1'b0;
    #1 check_all("async_rst", 1'b0, 8'h00, 3'd0, 1'b1, 1'b0, 3'b000, 1'b0);
    @(negedge clk);
    drive(1'b0, 8'h00, 1'b0, 3'b000, 8'h00, 1'b0);
    rst_n = 1'b1;

    // Channel-0 output path: ch0/ch1 corrupted, ch2 clean.
    @(negedge clk) drive(1'b1, 8'h00, 1'b0, 3'b011, 8'h0F, 1'b0);
    @(posedge clk);
    #1 chk("vote1.rd_data", 32'(rd_data), 32'h0F);
    chk("vote0.rd_data", 32'(rd_data0), 32'h0F);
    @(negedge clk) drive(1'b0, 8'h00, 1'b1, 3'b000, 8'h00, 1'b0);
    @(posedge clk);
    #1 chk("vote0.mismatch_ch", 32'(mismatch_ch0), 32'b100);
    chk("vote0.mismatch", 32'(mismatch0), 32'h1);
    chk("vote0.rd_valid", 32'(rd_valid0), 32'h0);
    @(negedge clk) drive(1'b0, 8'h00, 1'b0, 3'b000, 8'h00, 1'b0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
